// File: rtl/seg7_scan_capture.sv
// Capture side of a 4-digit multiplexed 7-segment bus: synchronizes the pins,
// debounces each digit slot and rebuilds the displayed 16-bit hex value.
module seg7_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  anodes,
  input  logic [6:0]  segments,
  output logic [15:0] value,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        anode_err,
  output logic        seq_err,
  output logic        timeout
);

  localparam logic [7:0]  STABLE_MAX   = 8'(STABLE_CYCLES);
  localparam logic [7:0]  STABLE_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT_D0 = 2'd0,
    S_COL1    = 2'd1,
    S_COL2    = 2'd2,
    S_COL3    = 2'd3
  } state_t;

  logic [10:0] sync1_r, sync2_r, pat_r;
  logic [7:0]  cnt_r;
  logic [15:0] idle_r;
  logic [11:0] pend_val_r;
  logic [2:0]  pend_err_r;
  state_t      state_r;

  logic        commit_s, is_digit_s, multi_s;
  logic [1:0]  digit_s;
  logic [4:0]  glyph_s;
  state_t      next_col_s;

  // Active-low segment pattern to {error, nibble}; unknown glyphs read as 0 with error.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg_n);
    logic [6:0] g;
    g = ~seg_n;
    case (g)
      7'h3F:   return {1'b0, 4'h0};
      7'h06:   return {1'b0, 4'h1};
      7'h5B:   return {1'b0, 4'h2};
      7'h4F:   return {1'b0, 4'h3};
      7'h66:   return {1'b0, 4'h4};
      7'h6D:   return {1'b0, 4'h5};
      7'h7D:   return {1'b0, 4'h6};
      7'h07:   return {1'b0, 4'h7};
      7'h7F:   return {1'b0, 4'h8};
      7'h6F:   return {1'b0, 4'h9};
      7'h77:   return {1'b0, 4'hA};
      7'h7C:   return {1'b0, 4'hB};
      7'h39:   return {1'b0, 4'hC};
      7'h5E:   return {1'b0, 4'hD};
      7'h79:   return {1'b0, 4'hE};
      7'h71:   return {1'b0, 4'hF};
      default: return {1'b1, 4'h0};
    endcase
  endfunction

  // Two-flop synchronizer, pattern register and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 11'h7FF;
      sync2_r <= 11'h7FF;
      pat_r   <= 11'h7FF;
      cnt_r   <= 8'd0;
    end else begin
      sync1_r <= {anodes, segments};
      sync2_r <= sync1_r;
      pat_r   <= sync2_r;
      if (sync2_r != pat_r) begin
        cnt_r <= 8'd1;
      end else if (cnt_r != STABLE_MAX) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Commit strobe, anode classification, glyph decode and next collect state.
  always_comb begin
    commit_s   = (sync2_r == pat_r) && (cnt_r == STABLE_LAST);
    is_digit_s = 1'b1;
    multi_s    = 1'b0;
    digit_s    = 2'd0;
    glyph_s    = decode_glyph(sync2_r[6:0]);
    case (sync2_r[10:7])
      4'b1110: digit_s = 2'd0;
      4'b1101: digit_s = 2'd1;
      4'b1011: digit_s = 2'd2;
      4'b0111: digit_s = 2'd3;
      4'b1111: is_digit_s = 1'b0;
      default: begin
        is_digit_s = 1'b0;
        multi_s    = 1'b1;
      end
    endcase
    case (state_r)
      S_COL1:  next_col_s = S_COL2;
      S_COL2:  next_col_s = S_COL3;
      default: next_col_s = S_WAIT_D0;
    endcase
  end

  // Frame assembly FSM with inactivity timeout and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_WAIT_D0;
      idle_r      <= 16'd0;
      pend_val_r  <= 12'h000;
      pend_err_r  <= 3'b000;
      value       <= 16'h0000;
      digit_err   <= 4'b0000;
      frame_valid <= 1'b0;
      anode_err   <= 1'b0;
      seq_err     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      anode_err   <= 1'b0;
      seq_err     <= 1'b0;
      timeout     <= 1'b0;
      if (commit_s && multi_s) begin
        anode_err <= 1'b1;
      end
      if (commit_s && is_digit_s) begin
        idle_r <= 16'd0;
        if (state_r == S_WAIT_D0) begin
          if (digit_s == 2'd0) begin
            pend_val_r <= {8'h00, glyph_s[3:0]};
            pend_err_r <= {2'b00, glyph_s[4]};
            state_r    <= S_COL1;
          end
        end else if (digit_s == 2'(state_r)) begin
          case (digit_s)
            2'd1: begin
              pend_val_r[7:4] <= glyph_s[3:0];
              pend_err_r[1]   <= glyph_s[4];
            end
            2'd2: begin
              pend_val_r[11:8] <= glyph_s[3:0];
              pend_err_r[2]    <= glyph_s[4];
            end
            default: begin
              value       <= {glyph_s[3:0], pend_val_r};
              digit_err   <= {glyph_s[4], pend_err_r};
              frame_valid <= 1'b1;
            end
          endcase
          state_r <= next_col_s;
        end else if (digit_s == 2'd0) begin
          // Early digit0 restarts collection rather than waiting a full scan.
          seq_err    <= 1'b1;
          pend_val_r <= {8'h00, glyph_s[3:0]};
          pend_err_r <= {2'b00, glyph_s[4]};
          state_r    <= S_COL1;
        end else begin
          seq_err <= 1'b1;
          state_r <= S_WAIT_D0;
        end
      end else if (state_r == S_WAIT_D0) begin
        idle_r <= 16'd0;
      end else if (idle_r == TIMEOUT_LAST) begin
        timeout <= 1'b1;
        idle_r  <= 16'd0;
        state_r <= S_WAIT_D0;
      end else begin
        idle_r <= idle_r + 16'd1;
      end
    end
  end

endmodule
